// File: rtl/apb_initiator.sv
// Single-outstanding load/store requester for the peripheral bus.
// One SETUP/ACCESS transfer per request, with an optional wait-state timeout.
module apb_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wstb,
  input  logic                  req_write,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  pready,
  input  logic                  perr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t                state_reg, state_next;
  logic                  req_ready_reg, req_ready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0] pdata_reg, pdata_next;
  logic                  psel_reg, psel_next;
  logic                  penable_reg, penable_next;
  logic                  pwrite_reg, pwrite_next;
  logic [3:0]            pstb_reg, pstb_next;
  logic [15:0]           wait_cnt_reg, wait_cnt_next;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      paddr_reg     <= '0;
      pdata_reg     <= '0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      pstb_reg      <= 4'b0000;
      wait_cnt_reg  <= 16'd0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      paddr_reg     <= paddr_next;
      pdata_reg     <= pdata_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      pstb_reg      <= pstb_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    req_ready_next = req_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    paddr_next     = paddr_reg;
    pdata_next     = pdata_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    pstb_next      = pstb_reg;
    wait_cnt_next  = wait_cnt_reg;

    case (state_reg)
      IDLE: begin
        // req_ready comes up one edge after reset release, so no request is
        // taken on that first edge.
        if (!req_ready_reg) begin
          req_ready_next = 1'b1;
        end else if (req_valid) begin
          req_ready_next = 1'b0;
          paddr_next     = req_addr;
          pdata_next     = req_wdata;
          pstb_next      = req_write ? req_wstb : 4'b0000;
          pwrite_next    = req_write;
          wait_cnt_next  = 16'd0;
          state_next     = SETUP;
        end
      end
      SETUP: begin
        psel_next    = 1'b1;
        penable_next = 1'b0;
        state_next   = ACCESS;
      end
      ACCESS: begin
        // First cycle here is the bus setup phase; pready only counts once penable is up.
        if (!penable_reg) begin
          penable_next = 1'b1;
        end else if (pready) begin
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_rdata_next = pwrite_reg ? '0 : prdata;
          rsp_err_next   = perr;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else if (TIMEOUT_EN && (wait_cnt_reg == TIMEOUT_LAST)) begin
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          req_ready_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign paddr     = paddr_reg;
  assign pdata     = pdata_reg;
  assign psel      = psel_reg;
  assign penable   = penable_reg;
  assign pwrite    = pwrite_reg;
  assign pstb      = pstb_reg;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: the bench plays the bus responder and the core,
// and checks latency, bus stability, timeout, backpressure and async reset.
module tb_apb_initiator;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstb = 4'h0;
  logic        req_write = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata = 32'h0;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        pready = 1'b0;
  logic        perr = 1'b0;

  int checks = 0;
  int errors = 0;
  int lat, acc;

  always #5 pclk = ~pclk;

  apb_initiator #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(4)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstb(req_wstb), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstb(pstb), .pready(pready), .perr(perr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request and answers as responder: pready low for 'waits' ACCESS
  // cycles (perr/prdata scrambled meanwhile), then completes with rdata/err_in.
  task automatic do_xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstb, input logic write, input int waits,
                         input logic [31:0] rdata, input logic err_in,
                         output int lat_o, output int acc_o);
    int setup_n;
    int unstable;
    check_eq({name, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_wstb = wstb; req_write = write;
    @(negedge pclk);
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_wstb = ~wstb; req_write = ~write;
    lat_o = 0; acc_o = 0; setup_n = 0; unstable = 0;
    while (!rsp_valid && lat_o < 100) begin
      if (psel && !penable) setup_n++;
      if (psel && penable) begin
        acc_o++;
        if (paddr !== addr || pwrite !== write || pstb !== (write ? wstb : 4'h0) ||
            (write && pdata !== wdata))
          unstable++;
        if (acc_o > waits) begin
          pready = 1'b1; perr = err_in; prdata = rdata;
        end else begin
          pready = 1'b0; perr = acc_o[0]; prdata = $urandom;
        end
      end else begin
        pready = 1'b0; perr = 1'b0;
      end
      @(negedge pclk);
      lat_o++;
    end
    pready = 1'b0; perr = 1'b0;
    check_eq({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({name, ".setup_cycles"}, 32'(setup_n), 32'd1);
    check_eq({name, ".bus_stable"}, 32'(unstable), 32'd0);
    check_eq({name, ".psel_off"}, 32'(psel), 32'd0);
    check_eq({name, ".penable_off"}, 32'(penable), 32'd0);
    $display("xfer %s addr=0x%08h write=%0b lat=%0d access=%0d rdata=0x%08h err=%0b",
             name, addr, write, lat_o, acc_o, rsp_rdata, rsp_err);
  endtask

  task automatic drain(input string name);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    check_eq({name, ".drain_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({name, ".drain_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge pclk);
    check_eq("rst.req_ready", 32'(req_ready), 32'd0);
    check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst.psel", 32'(psel), 32'd0);
    check_eq("rst.paddr", paddr, 32'd0);
    presetn = 1'b1;
    check_eq("rel.req_ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge pclk);
    check_eq("rel.req_ready_after_edge", 32'(req_ready), 32'd1);

    // Load, zero wait
    do_xfer("load0", 32'h10, 32'h0, 4'hF, 1'b0, 0, 32'hDEADBEEF, 1'b0, lat, acc);
    check_eq("load0.lat", 32'(lat), 32'd3);
    check_eq("load0.access", 32'(acc), 32'd1);
    check_eq("load0.rdata", rsp_rdata, 32'hDEADBEEF);
    check_eq("load0.err", 32'(rsp_err), 32'd0);
    check_eq("load0.pstb", 32'(pstb), 32'd0);
    drain("load0");

    // Store, two wait states, unaligned address
    do_xfer("store2", 32'h13, 32'h11223344, 4'b0011, 1'b1, 2, 32'hCAFEF00D, 1'b0, lat, acc);
    check_eq("store2.lat", 32'(lat), 32'd5);
    check_eq("store2.access", 32'(acc), 32'd3);
    check_eq("store2.rdata", rsp_rdata, 32'd0);
    check_eq("store2.err", 32'(rsp_err), 32'd0);
    check_eq("store2.paddr_hold", paddr, 32'h13);
    check_eq("store2.pdata_hold", pdata, 32'h11223344);
    check_eq("store2.pstb_hold", 32'(pstb), 32'h3);
    check_eq("store2.pwrite_hold", 32'(pwrite), 32'd1);
    drain("store2");

    // Responder error after waits with perr toggling
    do_xfer("perr", 32'h20, 32'h0, 4'h0, 1'b0, 2, 32'h0BADF00D, 1'b1, lat, acc);
    check_eq("perr.lat", 32'(lat), 32'd5);
    check_eq("perr.err", 32'(rsp_err), 32'd1);
    check_eq("perr.rdata", rsp_rdata, 32'h0BADF00D);
    drain("perr");

    // pready on the 4th ACCESS cycle wins over timeout; perr toggled while waiting
    do_xfer("late_ok", 32'h24, 32'h0, 4'h0, 1'b0, 3, 32'h12345678, 1'b0, lat, acc);
    check_eq("late_ok.lat", 32'(lat), 32'd6);
    check_eq("late_ok.access", 32'(acc), 32'd4);
    check_eq("late_ok.err", 32'(rsp_err), 32'd0);
    check_eq("late_ok.rdata", rsp_rdata, 32'h12345678);
    drain("late_ok");

    // Timeout: no responder
    do_xfer("tmo", 32'h28, 32'h0, 4'h0, 1'b0, 1000, 32'hFFFFFFFF, 1'b0, lat, acc);
    check_eq("tmo.lat", 32'(lat), 32'd6);
    check_eq("tmo.access", 32'(acc), 32'd4);
    check_eq("tmo.err", 32'(rsp_err), 32'd1);
    check_eq("tmo.rdata", rsp_rdata, 32'd0);
    drain("tmo");

    // Backpressure with a pending request
    do_xfer("bp", 32'h30, 32'h0, 4'h0, 1'b0, 0, 32'hA5A5A5A5, 1'b0, lat, acc);
    req_valid = 1'b1; req_addr = 32'h34; req_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check_eq("bp.rsp_valid_held", 32'(rsp_valid), 32'd1);
      check_eq("bp.rdata_held", rsp_rdata, 32'hA5A5A5A5);
      check_eq("bp.req_ready_low", 32'(req_ready), 32'd0);
      check_eq("bp.no_psel", 32'(psel), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    check_eq("bp.release_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("bp.release_psel", 32'(psel), 32'd0);
    do_xfer("bp2", 32'h34, 32'h0, 4'h0, 1'b0, 0, 32'h5A5A5A5A, 1'b0, lat, acc);
    check_eq("bp2.lat", 32'(lat), 32'd3);
    check_eq("bp2.rdata", rsp_rdata, 32'h5A5A5A5A);
    drain("bp2");

    // Reset during ACCESS wait states
    req_valid = 1'b1; req_addr = 32'h40; req_wdata = 32'h99; req_wstb = 4'hF; req_write = 1'b1;
    @(negedge pclk);
    req_valid = 1'b0;
    begin
      int k;
      k = 0;
      while (!(psel && penable) && k < 20) begin
        @(negedge pclk);
        k++;
      end
    end
    check_eq("rstx.reached_access", 32'(psel & penable), 32'd1);
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    check_eq("rstx.psel", 32'(psel), 32'd0);
    check_eq("rstx.penable", 32'(penable), 32'd0);
    check_eq("rstx.paddr", paddr, 32'd0);
    check_eq("rstx.pdata", pdata, 32'd0);
    check_eq("rstx.pwrite", 32'(pwrite), 32'd0);
    check_eq("rstx.pstb", 32'(pstb), 32'd0);
    check_eq("rstx.req_ready", 32'(req_ready), 32'd0);
    check_eq("rstx.rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rstx.rsp_err", 32'(rsp_err), 32'd0);
    @(negedge pclk);
    check_eq("rstx.rsp_valid", 32'(rsp_valid), 32'd0);
    presetn = 1'b1;
    @(negedge pclk);
    check_eq("rstx.req_ready_after", 32'(req_ready), 32'd1);
    check_eq("rstx.rsp_valid_after", 32'(rsp_valid), 32'd0);
    check_eq("rstx.psel_after", 32'(psel), 32'd0);
    $display("xfer rst_mid_access addr=0x00000040 dropped");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
